// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Stream framing, FSM encoding and small decode helpers.
package prog_loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RECV_HI,
      S_RECV_LO,
      S_WRITE,
      S_CHECK,
      S_DONE,
      S_ERROR
   } state_t;

   localparam int unsigned TIMEOUT_DEFAULT = 1024;
   localparam int          WORDS_W         = 9;
   localparam logic [WORDS_W-1:0] MAX_WORDS = 9'd256;

   // A COUNT byte of zero stands for a full 256-word image.
   function automatic logic [WORDS_W-1:0] word_count(input logic [7:0] c);
      return (c == 8'd0) ? MAX_WORDS : {1'b0, c};
   endfunction

   function automatic logic accepts(input state_t s);
      return s inside {S_IDLE, S_RECV_HI, S_RECV_LO, S_CHECK};
   endfunction

endpackage

// File: rtl/prog_loader.sv
// Boot loader: byte stream -> 16-bit memory words, XOR-verified,
// holds the cpu in reset until a good image has been written.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int                    ADDR_WIDTH     = 8,
   parameter logic [ADDR_WIDTH-1:0] START_ADDR     = '0,
   parameter int                    TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  mem_write_enable,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [15:0]           mem_write_data,
   output logic                  loading,
   output logic                  cpu_reset,
   output logic                  done,
   output logic                  error,
   output logic [WORDS_W-1:0]    words_loaded
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   state_t               state_q, state_n;
   logic [7:0]           hi_q, hi_n;
   logic [7:0]           xor_q, xor_n;
   logic [WORDS_W-1:0]   total_q, total_n;
   logic [TW-1:0]        tmo_q, tmo_n;
   logic                 wr_n;
   logic [ADDR_WIDTH-1:0] addr_n;
   logic [15:0]          data_n;
   logic [WORDS_W-1:0]   words_n;
   logic                 xfer;
   logic                 tmo_hit;

   assign xfer    = in_valid && in_ready;
   assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_n = state_q;
      hi_n    = hi_q;
      xor_n   = xor_q;
      total_n = total_q;
      tmo_n   = '0;
      wr_n    = 1'b0;
      addr_n  = mem_address;
      data_n  = mem_write_data;
      words_n = words_loaded;
      unique case (state_q)
         S_IDLE: begin
            if (xfer) begin
               total_n = word_count(in_data);
               xor_n   = in_data;
               state_n = S_RECV_HI;
            end
         end
         S_RECV_HI: begin
            if (xfer) begin
               hi_n    = in_data;
               xor_n   = xor_q ^ in_data;
               state_n = S_RECV_LO;
            end else if (tmo_hit) begin
               state_n = S_ERROR;
            end else begin
               tmo_n = tmo_q + 1'b1;
            end
         end
         S_RECV_LO: begin
            if (xfer) begin
               xor_n   = xor_q ^ in_data;
               data_n  = {hi_q, in_data};
               addr_n  = START_ADDR + ADDR_WIDTH'(words_loaded);
               wr_n    = 1'b1;
               words_n = words_loaded + 1'b1;
               state_n = S_WRITE;
            end else if (tmo_hit) begin
               state_n = S_ERROR;
            end else begin
               tmo_n = tmo_q + 1'b1;
            end
         end
         S_WRITE: begin
            state_n = (words_loaded == total_q) ? S_CHECK : S_RECV_HI;
         end
         S_CHECK: begin
            if (xfer) begin
               state_n = (in_data == xor_q) ? S_DONE : S_ERROR;
            end else if (tmo_hit) begin
               state_n = S_ERROR;
            end else begin
               tmo_n = tmo_q + 1'b1;
            end
         end
         S_DONE:  state_n = S_DONE;
         S_ERROR: state_n = S_ERROR;
         default: state_n = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q          <= S_IDLE;
         hi_q             <= '0;
         xor_q            <= '0;
         total_q          <= '0;
         tmo_q            <= '0;
         in_ready         <= 1'b0;
         mem_write_enable <= 1'b0;
         mem_address      <= START_ADDR;
         mem_write_data   <= '0;
         loading          <= 1'b1;
         cpu_reset        <= 1'b1;
         done             <= 1'b0;
         error            <= 1'b0;
         words_loaded     <= '0;
      end else begin
         state_q          <= state_n;
         hi_q             <= hi_n;
         xor_q            <= xor_n;
         total_q          <= total_n;
         tmo_q            <= tmo_n;
         in_ready         <= accepts(state_n);
         mem_write_enable <= wr_n;
         mem_address      <= addr_n;
         mem_write_data   <= data_n;
         loading          <= (state_n != S_DONE);
         cpu_reset        <= (state_n != S_DONE);
         done             <= (state_n == S_DONE);
         error            <= (state_n == S_ERROR);
         words_loaded     <= words_n;
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: two instances (start 00 and FE) share one
// byte stream; writes are scoreboarded against queued expectations.
module tb_prog_loader;

   localparam int TMO = 1024;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;

   logic       a_in_ready, a_we, a_loading, a_cpu_reset, a_done, a_error;
   logic [7:0] a_addr;
   logic [15:0] a_data;
   logic [8:0] a_words;
   logic       b_in_ready, b_we, b_loading, b_cpu_reset, b_done, b_error;
   logic [7:0] b_addr;
   logic [15:0] b_data;
   logic [8:0] b_words;

   always #5 clock = ~clock;

   prog_loader #(.ADDR_WIDTH(8), .START_ADDR(8'h00), .TIMEOUT_CYCLES(TMO)) u_a (
      .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(a_in_ready), .mem_write_enable(a_we), .mem_address(a_addr),
      .mem_write_data(a_data), .loading(a_loading), .cpu_reset(a_cpu_reset),
      .done(a_done), .error(a_error), .words_loaded(a_words)
   );

   prog_loader #(.ADDR_WIDTH(8), .START_ADDR(8'hFE), .TIMEOUT_CYCLES(TMO)) u_b (
      .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(b_in_ready), .mem_write_enable(b_we), .mem_address(b_addr),
      .mem_write_data(b_data), .loading(b_loading), .cpu_reset(b_cpu_reset),
      .done(b_done), .error(b_error), .words_loaded(b_words)
   );

   typedef struct {
      int          n;
      logic [15:0] w0;
      logic [15:0] w1;
      logic [7:0]  adj;
      bit          hold;
      bit          ok;
   } vec_t;

   vec_t        tbl[6];
   logic [23:0] qa[$];
   logic [23:0] qb[$];
   int          ntests = 0;
   int          nfail = 0;
   bit          track = 1'b0;
   int          lowcnt = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   always @(posedge clock) begin
      #1;
      if (track && !a_in_ready) lowcnt++;
      if (a_we) begin
         check("a_ready_during_write", 32'(a_in_ready), 0);
         if (qa.size() == 0) begin
            ntests++;
            nfail++;
            $display("FAIL a_unexpected_write: got %0h:%0h, required none",
                     a_addr, a_data);
         end else begin
            check("a_write", {8'h00, a_addr, a_data}, 32'(qa.pop_front()));
         end
      end
      if (b_we) begin
         if (qb.size() == 0) begin
            ntests++;
            nfail++;
            $display("FAIL b_unexpected_write: got %0h:%0h, required none",
                     b_addr, b_data);
         end else begin
            check("b_write", {8'h00, b_addr, b_data}, 32'(qb.pop_front()));
         end
      end
   end

   function automatic logic [15:0] word_of(input vec_t v, input int i);
      if (i == 0) return v.w0;
      if (i == 1) return v.w1;
      return 16'(i * 16'h0137) ^ 16'hC35A;
   endfunction

   // Called at a negedge; returns at the negedge after the byte is taken.
   task automatic send(input logic [7:0] b);
      int w = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (!a_in_ready && w < 50) begin
         @(negedge clock);
         w++;
      end
      if (w >= 50) begin
         ntests++;
         nfail++;
         $display("FAIL send_wait: in_ready got 0, required 1");
      end
      @(negedge clock);
   endtask

   task automatic gap(input bit hold);
      if (!hold) begin
         in_valid = 1'b0;
         @(negedge clock);
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset    = 1'b1;
      in_valid = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_a_ready"},   32'(a_in_ready), 0);
      check({tag, "_a_we"},      32'(a_we), 0);
      check({tag, "_a_addr"},    32'(a_addr), 32'h00);
      check({tag, "_a_data"},    32'(a_data), 0);
      check({tag, "_a_loading"}, 32'(a_loading), 1);
      check({tag, "_a_cpu_rst"}, 32'(a_cpu_reset), 1);
      check({tag, "_a_done"},    32'(a_done), 0);
      check({tag, "_a_error"},   32'(a_error), 0);
      check({tag, "_a_words"},   32'(a_words), 0);
      check({tag, "_b_addr"},    32'(b_addr), 32'hFE);
      check({tag, "_b_ready"},   32'(b_in_ready), 0);
   endtask

   task automatic load_and_check(input vec_t v, input int k);
      logic [7:0]  cnt;
      logic [7:0]  x;
      logic [15:0] w;
      cnt = 8'(v.n);
      x   = cnt;
      send(cnt);
      gap(v.hold);
      lowcnt = 0;
      track  = v.hold;
      for (int i = 0; i < v.n; i++) begin
         w = word_of(v, i);
         x = x ^ w[15:8] ^ w[7:0];
         send(w[15:8]);
         gap(v.hold);
         qa.push_back({8'(i), w});
         qb.push_back({8'(8'hFE + 8'(i)), w});
         send(w[7:0]);
         gap(v.hold);
      end
      track = 1'b0;
      send(x ^ v.adj);
      in_valid = 1'b0;
      repeat (2) @(negedge clock);
      check($sformatf("v%0d_a_done", k),    32'(a_done), 32'(v.ok));
      check($sformatf("v%0d_a_error", k),   32'(a_error), 32'(!v.ok));
      check($sformatf("v%0d_a_cpu_rst", k), 32'(a_cpu_reset), 32'(!v.ok));
      check($sformatf("v%0d_a_loading", k), 32'(a_loading), 32'(!v.ok));
      check($sformatf("v%0d_a_words", k),   32'(a_words), 32'(v.n));
      check($sformatf("v%0d_a_ready", k),   32'(a_in_ready), 0);
      check($sformatf("v%0d_b_done", k),    32'(b_done), 32'(v.ok));
      check($sformatf("v%0d_b_words", k),   32'(b_words), 32'(v.n));
      check($sformatf("v%0d_qa_left", k),   32'(qa.size()), 0);
      check($sformatf("v%0d_qb_left", k),   32'(qb.size()), 0);
      if (v.hold)
         check($sformatf("v%0d_ready_low", k), 32'(lowcnt), 32'(v.n));
      in_valid = 1'b1;
      in_data  = 8'h55;
      repeat (4) @(negedge clock);
      in_valid = 1'b0;
      check($sformatf("v%0d_words_hold", k), 32'(a_words), 32'(v.n));
      check($sformatf("v%0d_we_term", k),    32'(a_we), 0);
   endtask

   initial begin
      tbl[0] = '{2,   16'h1234, 16'hABCD, 8'h00, 1'b0, 1'b1};
      tbl[1] = '{2,   16'h1234, 16'hABCD, 8'h09, 1'b0, 1'b0};
      tbl[2] = '{5,   16'h0001, 16'hFFFF, 8'h00, 1'b1, 1'b1};
      tbl[3] = '{3,   16'hBEEF, 16'h0F0F, 8'h00, 1'b0, 1'b1};
      tbl[4] = '{256, 16'h8000, 16'h7FFF, 8'h00, 1'b1, 1'b1};
      tbl[5] = '{1,   16'h2222, 16'h0000, 8'h80, 1'b1, 1'b0};

      reset = 1'b1;
      repeat (3) @(negedge clock);
      check_reset_vals("rst");
      reset = 1'b0;
      @(negedge clock);
      check("rdy_after_reset", 32'(a_in_ready), 1);

      for (int k = 0; k < 6; k++) begin
         do_reset();
         load_and_check(tbl[k], k);
      end

      do_reset();
      send(8'h02);
      send(8'h11);
      in_valid = 1'b0;
      repeat (TMO - 4) @(negedge clock);
      check("tmo_early_error", 32'(a_error), 0);
      repeat (8) @(negedge clock);
      check("tmo_error", 32'(a_error), 1);
      check("tmo_cpu_rst", 32'(a_cpu_reset), 1);
      check("tmo_ready", 32'(a_in_ready), 0);
      check("tmo_done", 32'(a_done), 0);

      do_reset();
      repeat (5000) @(negedge clock);
      check("idle_error", 32'(a_error), 0);
      check("idle_ready", 32'(a_in_ready), 1);

      do_reset();
      send(8'h02);
      send(8'h77);
      in_valid = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      check_reset_vals("midrst");
      reset = 1'b0;
      @(negedge clock);
      load_and_check(tbl[0], 6);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
